// File: rtl/bsg_fifo_reorder_multi.sv
// -----------------------------------------------------------------------------
// bsg_fifo_reorder_multi
//
// Reorder FIFO. Entry ids are handed out in order through the alloc port.
// Data for any allocated id may be written later, in any order, through
// write_ports_p independent random-access write ports. The dequeue side
// presents the oldest allocated entry as soon as its data has arrived, so
// results always retire in allocation order.
//
// Optional feature (compile-time macro BSG_FIFO_REORDER_MULTI_BYPASS_EN):
//   defined   - a legal write to the oldest entry is forwarded to the deq
//               port in the same cycle (zero write-to-deq latency).
//   undefined - the written entry becomes visible at deq the cycle after
//               the write.
//
// Ports
//   clk_i          sole clock, rising edge
//   reset_n_i      asynchronous active-low reset
//   alloc_v_o      an entry id can be allocated (FIFO not full)
//   alloc_id_o     id handed out on alloc_yumi_i
//   alloc_yumi_i   consume the offered id
//   write_v_i      per-port write strobe
//   write_id_i     per-port target id, port p at [p*lg_els_lp +: lg_els_lp]
//   write_data_i   per-port data, port p at [p*width_p +: width_p]
//   deq_v_o        oldest allocated entry holds data
//   deq_data_o     data of the oldest entry
//   deq_id_o       id of the oldest entry (read pointer)
//   deq_yumi_i     retire the oldest entry
//   count_o        allocated-but-not-dequeued entries
//   empty_o        count_o == 0
//   full_o         count_o == els_p
//   error_o        sticky protocol error, cleared only by reset
// -----------------------------------------------------------------------------
module bsg_fifo_reorder_multi #(
  parameter  int width_p       = 32,
  parameter  int els_p         = 8,
  parameter  int write_ports_p = 2,
  localparam int lg_els_lp     = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int lg_cnt_lp     = ((els_p + 1) > 1) ? $clog2(els_p + 1) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_n_i,

  output logic                               alloc_v_o,
  output logic [lg_els_lp-1:0]               alloc_id_o,
  input  logic                               alloc_yumi_i,

  input  logic [write_ports_p-1:0]           write_v_i,
  input  logic [write_ports_p*lg_els_lp-1:0] write_id_i,
  input  logic [write_ports_p*width_p-1:0]   write_data_i,

  output logic                               deq_v_o,
  output logic [width_p-1:0]                 deq_data_o,
  output logic [lg_els_lp-1:0]               deq_id_o,
  input  logic                               deq_yumi_i,

  output logic [lg_cnt_lp-1:0]               count_o,
  output logic                               empty_o,
  output logic                               full_o,
  output logic                               error_o
);

  localparam logic [lg_els_lp-1:0] last_id_lp = lg_els_lp'(els_p - 1);
  localparam logic [lg_cnt_lp-1:0] els_cnt_lp = lg_cnt_lp'(els_p);

  logic [lg_els_lp-1:0] rptr_r, wptr_r;
  logic [lg_cnt_lp-1:0] count_r;
  logic [els_p-1:0]     valid_r, valid_next;
  logic                 error_r;
  logic [width_p-1:0]   mem_r [els_p];

  logic [lg_els_lp-1:0] wid   [write_ports_p];
  logic [width_p-1:0]   wdata [write_ports_p];
  logic [write_ports_p-1:0] in_win, dup, accept;

  logic alloc_fire, deq_fire;
  logic byp_hit;
  logic [width_p-1:0] byp_data;
  logic err_set;

  function automatic logic [lg_els_lp-1:0] ptr_inc(input logic [lg_els_lp-1:0] p);
    return (p == last_id_lp) ? '0 : p + lg_els_lp'(1);
  endfunction

  assign empty_o    = (count_r == '0);
  assign full_o     = (count_r == els_cnt_lp);
  assign alloc_v_o  = ~full_o;
  assign alloc_id_o = wptr_r;
  assign deq_id_o   = rptr_r;
  assign count_o    = count_r;
  assign error_o    = error_r;

  // Write-port qualification. The window check uses the pre-edge pointers,
  // so an id being allocated this cycle is not yet writable.
  always_comb begin
    for (int p = 0; p < write_ports_p; p++) begin
      wid[p]    = write_id_i[p*lg_els_lp +: lg_els_lp];
      wdata[p]  = write_data_i[p*width_p +: width_p];
      in_win[p] = 1'b0;
      dup[p]    = 1'b0;
      accept[p] = 1'b0;
    end
    for (int p = 0; p < write_ports_p; p++) begin
      // offset of the target from rptr, modulo els_p; inside the window if
      // it is smaller than the number of allocated entries
      if (int'(wid[p]) >= els_p)
        in_win[p] = 1'b0;
      else if (wid[p] >= rptr_r)
        in_win[p] = int'(wid[p] - rptr_r) < int'(count_r);
      else
        in_win[p] = (int'(wid[p]) + els_p - int'(rptr_r)) < int'(count_r);

      // a lower-numbered strobed port to the same id wins the conflict
      for (int q = 0; q < p; q++)
        if (write_v_i[q] && (wid[q] == wid[p])) dup[p] = 1'b1;

      if (write_v_i[p] && in_win[p] && !dup[p])
        accept[p] = ~valid_r[wid[p]];
    end
  end

`ifdef BSG_FIFO_REORDER_MULTI_BYPASS_EN
  // Accepted writes always target distinct ids, so at most one port hits.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (!empty_o && !valid_r[rptr_r]) begin
      for (int p = 0; p < write_ports_p; p++) begin
        if (accept[p] && (wid[p] == rptr_r)) begin
          byp_hit  = 1'b1;
          byp_data = wdata[p];
        end
      end
    end
  end
`else
  assign byp_hit  = 1'b0;
  assign byp_data = '0;
`endif

  assign deq_v_o    = (valid_r[rptr_r] | byp_hit) & ~empty_o;
  assign deq_data_o = byp_hit ? byp_data : mem_r[rptr_r];

  // A full FIFO stays unallocatable even if it is dequeued this cycle.
  assign alloc_fire = alloc_yumi_i & alloc_v_o;
  assign deq_fire   = deq_yumi_i & deq_v_o;

  // Every strobed-but-rejected port is an error; in a same-id conflict the
  // losing port is the one rejected, so the conflict is flagged too.
  assign err_set = (alloc_yumi_i & ~alloc_v_o)
                 | (deq_yumi_i & ~deq_v_o)
                 | (|(write_v_i & ~accept));

  // An accepted write to rptr while rptr is dequeued can only be a bypass
  // (a valid rptr rejects writes), and that entry retires without ever
  // becoming valid.
  always_comb begin
    valid_next = valid_r;
    if (deq_fire) valid_next[rptr_r] = 1'b0;
    for (int p = 0; p < write_ports_p; p++)
      if (accept[p] && !(deq_fire && (wid[p] == rptr_r)))
        valid_next[wid[p]] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr_r  <= '0;
      wptr_r  <= '0;
      count_r <= '0;
      valid_r <= '0;
      error_r <= 1'b0;
    end else begin
      if (alloc_fire) wptr_r <= ptr_inc(wptr_r);
      if (deq_fire)   rptr_r <= ptr_inc(rptr_r);
      case ({alloc_fire, deq_fire})
        2'b10:   count_r <= count_r + lg_cnt_lp'(1);
        2'b01:   count_r <= count_r - lg_cnt_lp'(1);
        default: count_r <= count_r;
      endcase
      valid_r <= valid_next;
      if (err_set) error_r <= 1'b1;
    end
  end

  // Storage is not reset; the valid bits define which entries are live.
  always_ff @(posedge clk_i) begin
    for (int p = 0; p < write_ports_p; p++)
      if (accept[p]) mem_r[wid[p]] <= wdata[p];
  end

endmodule

// File: tb/tb_bsg_fifo_reorder_multi.sv
// -----------------------------------------------------------------------------
// tb_bsg_fifo_reorder_multi
//
// Self-checking bench. Main instance: width 32, 8 entries, 2 write ports.
// Second instance: width 8, 5 entries, 1 write port, for pointer wrap on a
// non-power-of-two depth. Expected deq data is queued in allocation order
// and compared as entries retire.
// -----------------------------------------------------------------------------
module tb_bsg_fifo_reorder_multi;

  localparam int W  = 32;
  localparam int E  = 8;
  localparam int P  = 2;
  localparam int LE = 3;
  localparam int LC = 4;

  localparam int W5  = 8;
  localparam int E5  = 5;
  localparam int LE5 = 3;
  localparam int LC5 = 3;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic reset_n_i;

  logic            alloc_v_o, alloc_yumi_i;
  logic [LE-1:0]   alloc_id_o;
  logic [P-1:0]    write_v_i;
  logic [P*LE-1:0] write_id_i;
  logic [P*W-1:0]  write_data_i;
  logic            deq_v_o, deq_yumi_i;
  logic [W-1:0]    deq_data_o;
  logic [LE-1:0]   deq_id_o;
  logic [LC-1:0]   count_o;
  logic            empty_o, full_o, error_o;

  logic            alloc_v5, alloc_yumi5;
  logic [LE5-1:0]  alloc_id5;
  logic [0:0]      write_v5;
  logic [LE5-1:0]  write_id5;
  logic [W5-1:0]   write_data5;
  logic            deq_v5, deq_yumi5;
  logic [W5-1:0]   deq_data5;
  logic [LE5-1:0]  deq_id5;
  logic [LC5-1:0]  count5;
  logic            empty5, full5, error5;

  bsg_fifo_reorder_multi #(.width_p(W), .els_p(E), .write_ports_p(P)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .alloc_v_o(alloc_v_o), .alloc_id_o(alloc_id_o), .alloc_yumi_i(alloc_yumi_i),
    .write_v_i(write_v_i), .write_id_i(write_id_i), .write_data_i(write_data_i),
    .deq_v_o(deq_v_o), .deq_data_o(deq_data_o), .deq_id_o(deq_id_o),
    .deq_yumi_i(deq_yumi_i), .count_o(count_o), .empty_o(empty_o),
    .full_o(full_o), .error_o(error_o)
  );

  bsg_fifo_reorder_multi #(.width_p(W5), .els_p(E5), .write_ports_p(1)) dut5 (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .alloc_v_o(alloc_v5), .alloc_id_o(alloc_id5), .alloc_yumi_i(alloc_yumi5),
    .write_v_i(write_v5), .write_id_i(write_id5), .write_data_i(write_data5),
    .deq_v_o(deq_v5), .deq_data_o(deq_data5), .deq_id_o(deq_id5),
    .deq_yumi_i(deq_yumi5), .count_o(count5), .empty_o(empty5),
    .full_o(full5), .error_o(error5)
  );

  int n_cmp = 0;
  int n_mis = 0;
  logic [W-1:0]  sb  [$];
  logic [W5-1:0] sb5 [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    alloc_yumi_i = 1'b0;
    deq_yumi_i   = 1'b0;
    write_v_i    = '0;
    write_id_i   = '0;
    write_data_i = '0;
    alloc_yumi5  = 1'b0;
    deq_yumi5    = 1'b0;
    write_v5     = '0;
    write_id5    = '0;
    write_data5  = '0;
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk_i);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset_n_i = 1'b0;
    sb.delete();
    sb5.delete();
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    #1;
  endtask

  task automatic wr(input int port, input int id, input logic [W-1:0] d);
    write_v_i[port]              = 1'b1;
    write_id_i[port*LE +: LE]    = LE'(id);
    write_data_i[port*W +: W]    = d;
  endtask

  task automatic alloc_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      alloc_yumi_i = 1'b1;
      step();
    end
  endtask

  task automatic deq_one(input string tag);
    int t;
    logic [W-1:0] exp;
    t = 0;
    while (!deq_v_o && t < 20) begin
      step();
      t++;
    end
    if (!deq_v_o) begin
      chk({tag, "_timeout"}, 64'd0, 64'd1);
    end else if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      exp = sb.pop_front();
      chk(tag, deq_data_o, exp);
      deq_yumi_i = 1'b1;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_id, exp_deq_id, prev_id;
    logic have_prev;
    logic [W5-1:0] d5;

    idle();
    reset_n_i = 1'b0;
    #12;
    // outputs while reset is held
    chk("rst_alloc_v", alloc_v_o, 1);
    chk("rst_alloc_id", alloc_id_o, 0);
    chk("rst_deq_v", deq_v_o, 0);
    chk("rst_deq_id", deq_id_o, 0);
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_error", error_o, 0);
    do_reset();

    // 8 back-to-back allocations fill the FIFO with ids 0..7
    for (int i = 0; i < E; i++) begin
      chk("fill_alloc_id", alloc_id_o, i);
      alloc_yumi_i = 1'b1;
      step();
    end
    chk("fill_full", full_o, 1);
    chk("fill_alloc_v", alloc_v_o, 0);
    chk("fill_count", count_o, E);

    // out-of-order completion retires in allocation order
    do_reset();
    alloc_cycles(3);
    for (int i = 0; i < 3; i++) sb.push_back(W'(32'h100 + i));
    wr(0, 2, 32'h102);
    step();
    wr(0, 1, 32'h101);
    step();
    chk("ooo_deq_v_before", deq_v_o, 0);
    wr(0, 0, 32'h100);
    #1;
`ifdef BSG_FIFO_REORDER_MULTI_BYPASS_EN
    chk("ooo_deq_v_same", deq_v_o, 1);
`else
    chk("ooo_deq_v_same", deq_v_o, 0);
`endif
    step();
    chk("ooo_deq_v_after", deq_v_o, 1);
    chk("ooo_deq_id", deq_id_o, 0);
    deq_one("ooo_d0");
    deq_one("ooo_d1");
    deq_one("ooo_d2");
    chk("ooo_empty", empty_o, 1);
    chk("ooo_error", error_o, 0);

    // two ports, two distinct ids, same cycle
    do_reset();
    alloc_cycles(2);
    wr(0, 0, 32'hA);
    wr(1, 1, 32'hB);
    sb.push_back(32'hA);
    sb.push_back(32'hB);
    step();
    chk("dual_deq_v", deq_v_o, 1);
    chk("dual_count", count_o, 2);
    deq_one("dual_d0");
    chk("dual_deq_v1", deq_v_o, 1);
    deq_one("dual_d1");
    chk("dual_error", error_o, 0);

    // asynchronous reset discards live entries immediately
    alloc_cycles(2);
    wr(0, 2, 32'h77);
    step();
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("async_count", count_o, 0);
    chk("async_empty", empty_o, 1);
    chk("async_deq_v", deq_v_o, 0);
    chk("async_rptr", deq_id_o, 0);
    do_reset();

    // same-id conflict: port 0 wins, error is sticky until reset
    alloc_cycles(1);
    wr(0, 0, 32'h1);
    wr(1, 0, 32'h2);
    sb.push_back(32'h1);
    step();
    chk("conf_error", error_o, 1);
    deq_one("conf_data");
    step();
    step();
    chk("conf_sticky", error_o, 1);
    do_reset();
    chk("conf_cleared", error_o, 0);

    // write to an unallocated id is dropped
    wr(0, 3, 32'hDEAD);
    step();
    chk("unalloc_error", error_o, 1);
    chk("unalloc_deq_v", deq_v_o, 0);
    chk("unalloc_count", count_o, 0);

    // second write to an already-valid entry is dropped
    do_reset();
    alloc_cycles(1);
    wr(0, 0, 32'h11);
    step();
    chk("rewr_error0", error_o, 0);
    wr(0, 0, 32'h22);
    sb.push_back(32'h11);
    step();
    chk("rewr_error1", error_o, 1);
    deq_one("rewr_data");

    // deq_yumi with nothing to dequeue
    do_reset();
    deq_yumi_i = 1'b1;
    step();
    chk("bad_deq_error", error_o, 1);
    chk("bad_deq_count", count_o, 0);

    // write in the same cycle as the allocation of its id is too early
    do_reset();
    alloc_yumi_i = 1'b1;
    wr(0, 0, 32'h33);
    step();
    chk("early_error", error_o, 1);
    chk("early_count", count_o, 1);
    step();
    chk("early_deq_v", deq_v_o, 0);

    // full FIFO: alloc with a same-cycle deq is still refused
    do_reset();
    alloc_cycles(E);
    for (int i = 0; i < E; i += 2) begin
      wr(0, i, W'(32'h200 + i));
      wr(1, i + 1, W'(32'h200 + i + 1));
      step();
    end
    for (int i = 0; i < E; i++) sb.push_back(W'(32'h200 + i));
    chk("fd_full", full_o, 1);
    chk("fd_deq_v", deq_v_o, 1);
    chk("fd_data", deq_data_o, sb.pop_front());
    alloc_yumi_i = 1'b1;
    deq_yumi_i   = 1'b1;
    step();
    chk("fd_error", error_o, 1);
    chk("fd_count", count_o, E - 1);
    chk("fd_wptr", alloc_id_o, 0);
    for (int i = 1; i < E; i++) deq_one("fd_drain");
    chk("fd_empty", empty_o, 1);

    // 20 alloc/write/deq cycles on the 5-entry instance: ids wrap 4 -> 0
    do_reset();
    exp_id     = 0;
    exp_deq_id = 0;
    have_prev  = 1'b0;
    prev_id    = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      chk("wrap_alloc_id", alloc_id5, exp_id);
      alloc_yumi5 = 1'b1;
      if (have_prev) begin
        d5 = W5'(cyc * 7 + 3);
        write_v5    = 1'b1;
        write_id5   = LE5'(prev_id);
        write_data5 = d5;
        sb5.push_back(d5);
      end
      if (deq_v5) begin
        chk("wrap_deq_id", deq_id5, exp_deq_id);
        if (sb5.size() == 0) chk("wrap_sb_empty", 64'd0, 64'd1);
        else chk("wrap_deq_data", deq_data5, sb5.pop_front());
        deq_yumi5  = 1'b1;
        exp_deq_id = (exp_deq_id + 1) % E5;
      end
      step();
      prev_id   = exp_id;
      have_prev = 1'b1;
      exp_id    = (exp_id + 1) % E5;
    end
    chk("wrap_deq_count", exp_deq_id, (20 - 2) % E5);
    chk("wrap_count", count5, 2);
    chk("wrap_error", error5, 0);

    // write to rptr with a same-cycle deq_yumi
    do_reset();
    alloc_cycles(1);
    wr(0, 0, 32'h55);
    deq_yumi_i = 1'b1;
    #1;
`ifdef BSG_FIFO_REORDER_MULTI_BYPASS_EN
    chk("byp_deq_v", deq_v_o, 1);
    chk("byp_data", deq_data_o, 32'h55);
    step();
    chk("byp_count", count_o, 0);
    chk("byp_deq_v_after", deq_v_o, 0);
    chk("byp_error", error_o, 0);
`else
    chk("byp_deq_v", deq_v_o, 0);
    step();
    chk("byp_count", count_o, 1);
    chk("byp_error", error_o, 1);
    chk("byp_deq_v_after", deq_v_o, 1);
    chk("byp_data_after", deq_data_o, 32'h55);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
